time_set_ctrl: RTL
==================

Name: time_set_ctrl

Overview:
- Button-driven controller that sequences manual setting of the clock's hour/min/sec counters and the alarm time.
- Walks the user through six fields, edits a two-digit BCD value with single-step and auto-repeat increment, then commits it:
  - time fields: one-cycle load strobe to the counters, with the value on set_num1/set_num2;
  - alarm fields: internal alarm register, which feeds the beeper compare logic.
- Sits between the front-panel buttons and the counter/alarm datapath.

Parameters:
- HOLD_TICKS, 4: ticks inc must stay held before auto-repeat starts (1 s at 4 Hz).
- TIMEOUT_TICKS, 40: ticks with no button edge before an edit is abandoned (10 s).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low; one clock only, no other clock domains
- tick  in  1  4 Hz single-cycle enable, synchronous to clk
- btn_mode  in  1  debounced, synchronised level; press = rising edge
- btn_inc  in  1  debounced, synchronised level
- cur_time  in  24  {hour_t, hour_o, min_t, min_o, sec_t, sec_o} BCD from the counters
- set_num1  out  4  edit value, tens digit
- set_num2  out  4  edit value, ones digit
- load_hour  out  1  one-cycle commit strobe
- load_min  out  1  one-cycle commit strobe
- load_sec  out  1  one-cycle commit strobe
- alarm_time  out  24  stored alarm, same packing as cur_time
- editing  out  1  high in any non-RUN state
- field  out  3  current field: 0=HOUR, 1=MIN, 2=SEC, 3=AL_HOUR, 4=AL_MIN, 5=AL_SEC

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=RUN, field=0, alarm_time=0, set_num=0, all loads=0, editing=0;
  - repeat/timeout counters and button history regs cleared.
  - Reset mid-edit abandons the edit; no load is issued.
- Edge detect: prev register per button; edge = level & ~prev. Actions take effect at the same clk edge; outputs are registered and visible next cycle.
- States: RUN, SEED, EDIT, COMMIT.
- RUN:
  - set_num=0.
  - mode edge -> SEED with field=0. inc ignored.
- SEED (1 cycle):
  - value = cur_time slice for fields 0-2, or alarm_time slice for fields 3-5.
  - Timeout and repeat counters cleared. -> EDIT.
- EDIT:
  - set_num = value.
  - inc edge: value = BCD increment modulo LIMIT (24 for hour fields, 60 otherwise).
    - ones 9 -> 0 with tens+1;
    - LIMIT-1 -> 00 (23->00, 59->00).
  - Auto-repeat: while inc is held, count ticks. Once the count reaches HOLD_TICKS, increment on every tick. Release clears the count.
  - mode edge -> COMMIT. Mode wins over a simultaneous inc edge; that inc is dropped.
  - Timeout: the idle counter increments on tick and clears on any button edge or while inc is held. Reaching TIMEOUT_TICKS -> RUN, no commit, field=0.
- COMMIT (1 cycle):
  - set_num holds the committed value.
  - Fields 0/1/2 pulse load_hour/load_min/load_sec high for exactly this cycle.
  - Fields 3/4/5 write the value into the alarm_time slice; it is visible the next cycle.
  - field<5 -> field+1, SEED. field==5 -> RUN, field=0.
- Invariants:
  - At most one load strobe is high at a time, and only in COMMIT.
  - Button edges arriving during SEED or COMMIT are ignored.
  - Value digits always stay valid BCD within LIMIT.
- tick is ignored outside EDIT.

Decomposition:
- Package time_set_pkg:
  - state enum (RUN, SEED, EDIT, COMMIT);
  - field codes;
  - LIMIT_HOUR=24, LIMIT_MINSEC=60;
  - a bcd2 increment-with-limit function.
- One natural sub-module: btn_edge (prev register plus edge output), instantiated twice.

Test Plan:
- Reset mid-EDIT (field=1, value 37) -> next cycle state RUN, loads 0, alarm_time 0, set_num 0.
- cur_time hour=09: mode, inc x3, mode -> load_hour high exactly one cycle with set_num1=1, set_num2=2; field becomes 1 and seeds from cur_time minutes.
- Wrap cases:
  - hour seeded 23, one inc -> 00;
  - minute 59, one inc -> 00;
  - minute 09, one inc -> 10.
- Hold inc for 10 ticks from sec=00 -> single step to 01, then +1 per tick after HOLD_TICKS held ticks, reaching 07.
- Walk all six fields, setting the alarm to 07:30:00 -> alarm_time=24'h073000; state RUN after the 6th mode; no load strobes during alarm commits.
- Timeout and collision:
  - 40 ticks idle in EDIT -> RUN with no load.
  - mode and inc edges in the same cycle -> commit of the unincremented value.

Source files
------------

// File: rtl/time_set_pkg.sv
// Shared types, limits and BCD helpers for the manual time/alarm setting controller.
package time_set_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SEED   = 2'd1,
    ST_EDIT   = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    FLD_HOUR    = 3'd0,
    FLD_MIN     = 3'd1,
    FLD_SEC     = 3'd2,
    FLD_AL_HOUR = 3'd3,
    FLD_AL_MIN  = 3'd4,
    FLD_AL_SEC  = 3'd5
  } field_e;

  localparam int LIMIT_HOUR   = 24;
  localparam int LIMIT_MINSEC = 60;

  // Anything at or above limit-1 (including non-BCD digits) rolls over to 00.
  function automatic logic [7:0] bcd2_inc(input logic [7:0] v, input int limit);
    logic [3:0] last_t;
    logic [3:0] last_o;
    last_t = 4'((limit - 1) / 10);
    last_o = 4'((limit - 1) % 10);
    if (v[3:0] > 4'd9 || v[7:4] > last_t || (v[7:4] == last_t && v[3:0] >= last_o)) begin
      bcd2_inc = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      bcd2_inc = {v[7:4] + 4'd1, 4'd0};
    end else begin
      bcd2_inc = {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

  function automatic int field_limit(input logic [2:0] f);
    if (f == FLD_HOUR || f == FLD_AL_HOUR) begin
      field_limit = LIMIT_HOUR;
    end else begin
      field_limit = LIMIT_MINSEC;
    end
  endfunction

  // idx 0/1/2 selects the hour/min/sec byte of a packed time word.
  function automatic logic [7:0] get_slice(input logic [23:0] t, input logic [1:0] idx);
    case (idx)
      2'd0:    get_slice = t[23:16];
      2'd1:    get_slice = t[15:8];
      2'd2:    get_slice = t[7:0];
      default: get_slice = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Front-panel / datapath bundle of the time setting controller.
interface time_set_ctrl_if;
  logic        tick;
  logic        btn_mode;
  logic        btn_inc;
  logic [23:0] cur_time;
  logic [3:0]  set_num1;
  logic [3:0]  set_num2;
  logic        load_hour;
  logic        load_min;
  logic        load_sec;
  logic [23:0] alarm_time;
  logic        editing;
  logic [2:0]  field;

  modport master (
    output tick, btn_mode, btn_inc, cur_time,
    input  set_num1, set_num2, load_hour, load_min, load_sec, alarm_time, editing, field
  );

  modport slave (
    input  tick, btn_mode, btn_inc, cur_time,
    output set_num1, set_num2, load_hour, load_min, load_sec, alarm_time, editing, field
  );
endinterface

// File: rtl/time_set_ctrl_btn_edge.sv
// Rising-edge detector for an already debounced, synchronised button level.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic prev_r;

  // history register of the button level
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= level;
    end
  end

  assign pulse = level & ~prev_r;

endmodule

// File: rtl/time_set_ctrl.sv
// Sequences manual setting of hour/min/sec counters and the alarm register from two buttons.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int HOLD_TICKS    = 4,
  parameter int TIMEOUT_TICKS = 40
) (
  input logic             clk,
  input logic             rst,
  time_set_ctrl_if.slave  bus
);

  localparam int REP_W  = $clog2(HOLD_TICKS + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [REP_W-1:0]  HOLD_C = REP_W'(HOLD_TICKS);
  localparam logic [IDLE_W-1:0] IDLE_C = IDLE_W'(TIMEOUT_TICKS);

  state_e            state_r, state_s;
  logic [2:0]        field_r, field_s;
  logic [7:0]        value_r, value_s;
  logic [23:0]       alarm_r, alarm_s;
  logic [REP_W-1:0]  rep_r, rep_s;
  logic [IDLE_W-1:0] idle_r, idle_s;
  logic [7:0]        set_num_r, set_num_s;
  logic [2:0]        load_r, load_s;
  logic              editing_r, editing_s;
  logic              mode_edge_s, inc_edge_s;

  btn_edge u_mode_edge (.clk(clk), .rst(rst), .level(bus.btn_mode), .pulse(mode_edge_s));
  btn_edge u_inc_edge  (.clk(clk), .rst(rst), .level(bus.btn_inc),  .pulse(inc_edge_s));

  // next-state, edit value, alarm update and registered-output next values
  always_comb begin
    state_s = state_r;
    field_s = field_r;
    value_s = value_r;
    alarm_s = alarm_r;
    rep_s   = rep_r;
    idle_s  = idle_r;
    case (state_r)
      ST_RUN: begin
        rep_s  = '0;
        idle_s = '0;
        if (mode_edge_s) begin
          state_s = ST_SEED;
          field_s = FLD_HOUR;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_SEED: begin
        rep_s   = '0;
        idle_s  = '0;
        state_s = ST_EDIT;
        if (field_r < FLD_AL_HOUR) begin
          value_s = get_slice(bus.cur_time, field_r[1:0]);
        end else begin
          value_s = get_slice(alarm_r, 2'(field_r - 3'd3));
        end
      end
      ST_EDIT: begin
        if (!bus.btn_inc) begin
          rep_s = '0;
        end else if (bus.tick && rep_r < HOLD_C) begin
          rep_s = rep_r + REP_W'(1);
        end else begin
          rep_s = rep_r;
        end
        if (mode_edge_s || inc_edge_s || bus.btn_inc) begin
          idle_s = '0;
        end else if (bus.tick) begin
          idle_s = idle_r + IDLE_W'(1);
        end else begin
          idle_s = idle_r;
        end
        // mode outranks both a coincident inc edge and an auto-repeat step
        if (mode_edge_s) begin
          state_s = ST_COMMIT;
        end else if (idle_s == IDLE_C) begin
          state_s = ST_RUN;
          field_s = FLD_HOUR;
        end else if (inc_edge_s || (bus.btn_inc && bus.tick && rep_r >= HOLD_C)) begin
          value_s = bcd2_inc(value_r, field_limit(field_r));
        end else begin
          value_s = value_r;
        end
      end
      ST_COMMIT: begin
        case (field_r)
          FLD_AL_HOUR: alarm_s[23:16] = value_r;
          FLD_AL_MIN:  alarm_s[15:8]  = value_r;
          FLD_AL_SEC:  alarm_s[7:0]   = value_r;
          default:     alarm_s        = alarm_r;
        endcase
        if (field_r >= FLD_AL_SEC) begin
          state_s = ST_RUN;
          field_s = FLD_HOUR;
        end else begin
          state_s = ST_SEED;
          field_s = field_r + 3'd1;
        end
      end
      default: begin
        state_s = ST_RUN;
        field_s = FLD_HOUR;
      end
    endcase

    load_s = 3'b000;
    if (state_s == ST_COMMIT) begin
      case (field_r)
        FLD_HOUR: load_s = 3'b001;
        FLD_MIN:  load_s = 3'b010;
        FLD_SEC:  load_s = 3'b100;
        default:  load_s = 3'b000;
      endcase
    end else begin
      load_s = 3'b000;
    end
    if (state_s == ST_RUN) begin
      set_num_s = 8'h00;
    end else begin
      set_num_s = value_s;
    end
    editing_s = (state_s != ST_RUN);
  end

  // controller state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= ST_RUN;
      field_r   <= 3'd0;
      value_r   <= 8'h00;
      alarm_r   <= 24'h000000;
      rep_r     <= '0;
      idle_r    <= '0;
      set_num_r <= 8'h00;
      load_r    <= 3'b000;
      editing_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      field_r   <= field_s;
      value_r   <= value_s;
      alarm_r   <= alarm_s;
      rep_r     <= rep_s;
      idle_r    <= idle_s;
      set_num_r <= set_num_s;
      load_r    <= load_s;
      editing_r <= editing_s;
    end
  end

  assign bus.set_num1   = set_num_r[7:4];
  assign bus.set_num2   = set_num_r[3:0];
  assign bus.load_hour  = load_r[0];
  assign bus.load_min   = load_r[1];
  assign bus.load_sec   = load_r[2];
  assign bus.alarm_time = alarm_r;
  assign bus.editing    = editing_r;
  assign bus.field      = field_r;

endmodule
